// File: rtl/sens_mux_fifo.sv
// sens_mux_fifo: multi-channel sensor ingest buffer.
// Merges NUM_CH sample streams into one shared FIFO through a round-robin arbiter.
// Each channel has a one-entry holding register in front of the arbiter. Each FIFO entry carries
// its source channel tag. Per-channel sticky overflow flags and a saturating drop counter record
// samples that could not be accepted.
//
// Ports
//   clk, rst        system clock, asynchronous active-high reset
//   sens_data       packed samples, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   sens_data_val   per-channel sample strobe
//   ch_enable       per-channel enable; disabled channels ignore new samples
//   rd_en           pop request
//   rd_data, rd_ch  registered read sample and its channel tag
//   rd_valid        one-cycle pulse, rd_data/rd_ch valid
//   empty, full     FIFO status
//   almost_full     level >= AFULL_LVL
//   level           entry count, 0..DEPTH
//   ovf_clr         per-channel sticky overflow clear
//   ovf_sticky      per-channel sticky overflow flag
//   drop_cnt        total dropped samples, saturating at 255
module sens_mux_fifo #(
   parameter int unsigned NUM_CH     = 4,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH      = 64,
   parameter int unsigned ADDR_WIDTH = 6,
   parameter int unsigned CH_W       = 2,
   parameter int unsigned AFULL_LVL  = 48
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_CH*DATA_WIDTH-1:0] sens_data,
   input  logic [NUM_CH-1:0]            sens_data_val,
   input  logic [NUM_CH-1:0]            ch_enable,
   input  logic                         rd_en,
   output logic [DATA_WIDTH-1:0]        rd_data,
   output logic [CH_W-1:0]              rd_ch,
   output logic                         rd_valid,
   output logic                         empty,
   output logic                         full,
   output logic                         almost_full,
   output logic [ADDR_WIDTH:0]          level,
   input  logic [NUM_CH-1:0]            ovf_clr,
   output logic [NUM_CH-1:0]            ovf_sticky,
   output logic [7:0]                   drop_cnt
);

   localparam int unsigned PTR_W   = ADDR_WIDTH + 1;
   localparam int unsigned ENTRY_W = CH_W + DATA_WIDTH;

   logic [NUM_CH-1:0]     hold_vld_q, hold_vld_d;
   logic [DATA_WIDTH-1:0] hold_data_q [NUM_CH];
   logic [CH_W-1:0]       rr_ptr_q, rr_ptr_d;

   logic                  grant_any;
   logic [CH_W-1:0]       grant_idx;
   logic [CH_W-1:0]       cand;
   logic [NUM_CH-1:0]     grant_vec;
   logic [NUM_CH-1:0]     load, drop;

   logic [ENTRY_W-1:0]    mem [DEPTH];
   logic [ENTRY_W-1:0]    rd_entry;
   logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d, level_d;
   logic                  wr_fire, rd_fire;

   logic [NUM_CH-1:0]     ovf_q, ovf_d;
   logic [7:0]            drop_cnt_q, drop_cnt_d;
   logic [15:0]           drop_sum;

   logic [DATA_WIDTH-1:0] rd_data_q;
   logic [CH_W-1:0]       rd_ch_q;
   logic                  rd_valid_q, empty_q, full_q, afull_q;
   logic [PTR_W-1:0]      level_q;

   // Round-robin arbiter: first valid holding register at or after rr_ptr wins.
   // full_q is the registered status of the current state, so a same-cycle pop never
   // makes room for a write.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      grant_vec = '0;
      cand      = '0;
      if (!full_q) begin
         for (int unsigned k = 0; k < NUM_CH; k++) begin
            cand = CH_W'((32'(rr_ptr_q) + k) % NUM_CH);
            if (!grant_any && hold_vld_q[cand]) begin
               grant_any = 1'b1;
               grant_idx = cand;
            end
         end
      end
      if (grant_any) begin
         grant_vec[grant_idx] = 1'b1;
      end
      rr_ptr_d = grant_any ? CH_W'((32'(grant_idx) + 1) % NUM_CH) : rr_ptr_q;
   end

   // Holding stage: a granted register can be reloaded in the same cycle it drains.
   always_comb begin
      load       = '0;
      drop       = '0;
      hold_vld_d = '0;
      drop_sum   = {8'd0, drop_cnt_q};
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         load[i]       = sens_data_val[i] & ch_enable[i] & (~hold_vld_q[i] | grant_vec[i]);
         drop[i]       = sens_data_val[i] & ch_enable[i] & hold_vld_q[i] & ~grant_vec[i];
         hold_vld_d[i] = load[i] | (hold_vld_q[i] & ~grant_vec[i]);
         drop_sum      = drop_sum + 16'(drop[i]);
      end
      drop_cnt_d = (drop_sum > 16'd255) ? 8'hFF : drop_sum[7:0];
      // Set wins over a same-cycle clear.
      ovf_d      = (ovf_q & ~ovf_clr) | drop;
   end

   // FIFO pointers and registered status derived from the next pointers.
   always_comb begin
      wr_fire  = grant_any;
      rd_fire  = rd_en & ~empty_q;
      wr_ptr_d = wr_ptr_q + PTR_W'(wr_fire);
      rd_ptr_d = rd_ptr_q + PTR_W'(rd_fire);
      level_d  = wr_ptr_d - rd_ptr_d;
      rd_entry = mem[rd_ptr_q[ADDR_WIDTH-1:0]];
   end

   always_ff @(posedge clk) begin
      if (wr_fire) begin
         mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= {grant_idx, hold_data_q[grant_idx]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_vld_q <= '0;
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            hold_data_q[i] <= '0;
         end
         rr_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         empty_q    <= 1'b1;
         full_q     <= 1'b0;
         afull_q    <= 1'b0;
         rd_data_q  <= '0;
         rd_ch_q    <= '0;
         rd_valid_q <= 1'b0;
         ovf_q      <= '0;
         drop_cnt_q <= '0;
      end else begin
         hold_vld_q <= hold_vld_d;
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (load[i]) begin
               hold_data_q[i] <= sens_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
         end
         rr_ptr_q   <= rr_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         empty_q    <= (level_d == '0);
         full_q     <= (level_d == PTR_W'(DEPTH));
         afull_q    <= (level_d >= PTR_W'(AFULL_LVL));
         rd_valid_q <= rd_fire;
         if (rd_fire) begin
            rd_data_q <= rd_entry[DATA_WIDTH-1:0];
            rd_ch_q   <= rd_entry[ENTRY_W-1:DATA_WIDTH];
         end
         ovf_q      <= ovf_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign rd_data     = rd_data_q;
   assign rd_ch       = rd_ch_q;
   assign rd_valid    = rd_valid_q;
   assign empty       = empty_q;
   assign full        = full_q;
   assign almost_full = afull_q;
   assign level       = level_q;
   assign ovf_sticky  = ovf_q;
   assign drop_cnt    = drop_cnt_q;

endmodule
